// File: rtl/tc_ram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter.
//   state_e       : sequencer states (IDLE, ISSUE, WAIT, DONE)
//   REQ_A / REQ_B : requester identifiers used for grant and ownership tracking
//   TIMEOUT_LIMIT : WAIT-state cycle count at which a read is abandoned
//                   (only used when TC_RAM_ARB_TIMEOUT_EN is defined)
package tc_ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/tc_ram_arbiter_pick.sv
// Combinational two-way round-robin picker.
//   req_a_i       : requester A wants the RAM
//   req_b_i       : requester B wants the RAM
//   last_i        : id of the requester granted most recently
//   grant_valid_o : at least one requester is asking
//   grant_id_o    : id of the chosen requester (REQ_A / REQ_B)
module tc_rr_pick2
  import tc_ram_arb_pkg::*;
(
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic last_i,
  output logic grant_valid_o,
  output logic grant_id_o
);

  // B wins when it is alone, or when both ask and A was served last.
  assign grant_valid_o = req_a_i | req_b_i;
  assign grant_id_o    = req_b_i & (~req_a_i | (last_i == REQ_A));

endmodule

// File: rtl/tc_ram_arbiter.sv
// Round-robin arbiter and sequencer in front of one latency-2 quad-word RAM.
// Requesters A and B each issue 4-word block reads or writes; commands are
// serialised onto the single RAM port, which this block drives with
// registered load/save/address/data. Read data and a one-cycle done pulse go
// back to the requester that won.
//   clk, rst            : clock, asynchronous active-low reset
//   x_req/x_we/x_addr   : requester command (held until x_done)
//   x_wdata             : four write words, word k at [k*BIT_WIDTH +: BIT_WIDTH]
//   x_done/x_rdata      : completion pulse and read data (valid with x_done)
//   mem_load/mem_save   : RAM read / write strobes (high only in ISSUE)
//   mem_address/mem_in* : RAM base address and write words
//   mem_ready/mem_out*  : RAM read completion and read words
//   timeout_err         : sticky read-timeout flag (TC_RAM_ARB_TIMEOUT_EN only)
// Optional build macro TC_RAM_ARB_TIMEOUT_EN adds an 8-bit WAIT watchdog.
module tc_ram_arbiter
  import tc_ram_arb_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_req,
  input  logic                   a_we,
  input  logic [ADDR_WIDTH-1:0]  a_addr,
  input  logic [4*BIT_WIDTH-1:0] a_wdata,
  output logic                   a_done,
  output logic [4*BIT_WIDTH-1:0] a_rdata,
  input  logic                   b_req,
  input  logic                   b_we,
  input  logic [ADDR_WIDTH-1:0]  b_addr,
  input  logic [4*BIT_WIDTH-1:0] b_wdata,
  output logic                   b_done,
  output logic [4*BIT_WIDTH-1:0] b_rdata,
  output logic                   mem_load,
  output logic                   mem_save,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [BIT_WIDTH-1:0]   mem_in0,
  output logic [BIT_WIDTH-1:0]   mem_in1,
  output logic [BIT_WIDTH-1:0]   mem_in2,
  output logic [BIT_WIDTH-1:0]   mem_in3,
  input  logic                   mem_ready,
  input  logic [BIT_WIDTH-1:0]   mem_out0,
  input  logic [BIT_WIDTH-1:0]   mem_out1,
  input  logic [BIT_WIDTH-1:0]   mem_out2,
  input  logic [BIT_WIDTH-1:0]   mem_out3
`ifdef TC_RAM_ARB_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  state_e                 state_q;
  logic                   last_q;
  logic                   owner_q;
  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [4*BIT_WIDTH-1:0] wdata_q;
  logic                   load_q;
  logic                   save_q;
  logic                   a_done_q;
  logic                   b_done_q;
  logic [4*BIT_WIDTH-1:0] a_rdata_q;
  logic [4*BIT_WIDTH-1:0] b_rdata_q;
`ifdef TC_RAM_ARB_TIMEOUT_EN
  logic [7:0]             wait_cnt_q;
  logic                   timeout_q;
`endif

  logic                   grantValid;
  logic                   grantId;
  logic                   selWe;
  logic [ADDR_WIDTH-1:0]  selAddr;
  logic [4*BIT_WIDTH-1:0] selWdata;
  logic [4*BIT_WIDTH-1:0] readWord;

  tc_rr_pick2 u_pick (
    .req_a_i       (a_req),
    .req_b_i       (b_req),
    .last_i        (last_q),
    .grant_valid_o (grantValid),
    .grant_id_o    (grantId)
  );

  // Command of whichever requester the picker chose this cycle.
  assign selWe    = (grantId == REQ_B) ? b_we    : a_we;
  assign selAddr  = (grantId == REQ_B) ? b_addr  : a_addr;
  assign selWdata = (grantId == REQ_B) ? b_wdata : a_wdata;
  assign readWord = {mem_out3, mem_out2, mem_out1, mem_out0};

  // Sequencer: every RAM-side and requester-side output is a flop, so the
  // strobes are glitch-free and change only on the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= REQ_B;
      owner_q   <= REQ_A;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      load_q    <= 1'b0;
      save_q    <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
`ifdef TC_RAM_ARB_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grantValid) begin
            owner_q <= grantId;
            last_q  <= grantId;
            we_q    <= selWe;
            addr_q  <= selAddr;
            wdata_q <= selWdata;
            save_q  <= selWe;
            load_q  <= ~selWe;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          save_q <= 1'b0;
          load_q <= 1'b0;
          // A write is committed by the RAM inside ISSUE, so it is done now.
          if (we_q) begin
            a_done_q <= (owner_q == REQ_A);
            b_done_q <= (owner_q == REQ_B);
            state_q  <= DONE;
          end else begin
`ifdef TC_RAM_ARB_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            if (owner_q == REQ_A) begin
              a_rdata_q <= readWord;
            end else begin
              b_rdata_q <= readWord;
            end
            a_done_q <= (owner_q == REQ_A);
            b_done_q <= (owner_q == REQ_B);
            state_q  <= DONE;
          end
`ifdef TC_RAM_ARB_TIMEOUT_EN
          // Watchdog: give up on a RAM that never answers and return zeros.
          else if (wait_cnt_q == TIMEOUT_LIMIT) begin
            if (owner_q == REQ_A) begin
              a_rdata_q <= '0;
            end else begin
              b_rdata_q <= '0;
            end
            a_done_q  <= (owner_q == REQ_A);
            b_done_q  <= (owner_q == REQ_B);
            timeout_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end
        DONE: begin
          a_done_q <= 1'b0;
          b_done_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_load    = load_q;
  assign mem_save    = save_q;
  assign mem_address = addr_q;
  assign mem_in0     = wdata_q[0*BIT_WIDTH +: BIT_WIDTH];
  assign mem_in1     = wdata_q[1*BIT_WIDTH +: BIT_WIDTH];
  assign mem_in2     = wdata_q[2*BIT_WIDTH +: BIT_WIDTH];
  assign mem_in3     = wdata_q[3*BIT_WIDTH +: BIT_WIDTH];
  assign a_done      = a_done_q;
  assign b_done      = b_done_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
`ifdef TC_RAM_ARB_TIMEOUT_EN
  assign timeout_err = timeout_q;
`endif

endmodule

// File: tb/tb_tc_ram_arbiter.sv
// Directed self-checking bench for tc_ram_arbiter with a behavioural
// latency-2 quad-word RAM. Timeout scenario is included when the build
// defines TC_RAM_ARB_TIMEOUT_EN.
module tb_tc_ram_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, b_addr;
  logic [63:0] a_wdata, b_wdata;
  logic        a_done, b_done;
  logic [63:0] a_rdata, b_rdata;
  logic        mem_load, mem_save, mem_ready;
  logic [15:0] mem_address;
  logic [15:0] mem_in0, mem_in1, mem_in2, mem_in3;
  logic [15:0] mem_out0, mem_out1, mem_out2, mem_out3;
`ifdef TC_RAM_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int vectors;
  int miscompares;

  logic [15:0] ram [0:255];
  logic        ramEnable;
  logic        loadSeen;

  tc_ram_arbiter #(.BIT_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_done      (a_done),
    .a_rdata     (a_rdata),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_done      (b_done),
    .b_rdata     (b_rdata),
    .mem_load    (mem_load),
    .mem_save    (mem_save),
    .mem_address (mem_address),
    .mem_in0     (mem_in0),
    .mem_in1     (mem_in1),
    .mem_in2     (mem_in2),
    .mem_in3     (mem_in3),
    .mem_ready   (mem_ready),
    .mem_out0    (mem_out0),
    .mem_out1    (mem_out1),
    .mem_out2    (mem_out2),
    .mem_out3    (mem_out3)
`ifdef TC_RAM_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM writes land on the falling edge of the save cycle.
  always @(negedge clk) begin
    if (mem_save) begin
      ram[mem_address[7:0]]        = mem_in0;
      ram[mem_address[7:0] + 8'd1] = mem_in1;
      ram[mem_address[7:0] + 8'd2] = mem_in2;
      ram[mem_address[7:0] + 8'd3] = mem_in3;
    end
  end

  // Reads: load seen on one edge, ready and data presented after the next.
  always @(posedge clk) begin
    loadSeen  <= mem_load & ramEnable;
    mem_ready <= loadSeen;
    if (loadSeen) begin
      mem_out0 <= ram[mem_address[7:0]];
      mem_out1 <= ram[mem_address[7:0] + 8'd1];
      mem_out2 <= ram[mem_address[7:0] + 8'd2];
      mem_out3 <= ram[mem_address[7:0] + 8'd3];
    end
  end

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int  cyc;
    bit  doneSeen;
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0;
    ramEnable = 1'b1;
    loadSeen  = 1'b0;
    mem_ready = 1'b0;
    mem_out0 = '0; mem_out1 = '0; mem_out2 = '0; mem_out3 = '0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_mem_load", 64'(mem_load), 64'd0);
    checkOutput("rst_mem_save", 64'(mem_save), 64'd0);
    checkOutput("rst_mem_address", 64'(mem_address), 64'd0);
    checkOutput("rst_mem_in0", 64'(mem_in0), 64'd0);
    checkOutput("rst_dones", {62'd0, a_done, b_done}, 64'd0);
    checkOutput("rst_a_rdata", a_rdata, 64'd0);
    checkOutput("rst_b_rdata", b_rdata, 64'd0);
`ifdef TC_RAM_ARB_TIMEOUT_EN
    checkOutput("rst_timeout_err", 64'(timeout_err), 64'd0);
`endif
    applyStimulus(1);
    rst = 1'b1;

    // Single write from A: save for one cycle, done two cycles on.
    $display("[TB] single write");
    a_req = 1; a_we = 1; a_addr = 16'h0010;
    a_wdata = {16'd4, 16'd3, 16'd2, 16'd1};
    applyStimulus(1);
    checkOutput("wr_save", {62'd0, mem_save, mem_load}, 64'd2);
    checkOutput("wr_addr", 64'(mem_address), 64'h0010);
    checkOutput("wr_data", {mem_in3, mem_in2, mem_in1, mem_in0}, 64'h0004_0003_0002_0001);
    checkOutput("wr_done_early", {62'd0, a_done, b_done}, 64'd0);
    applyStimulus(1);
    checkOutput("wr_save_off", 64'(mem_save), 64'd0);
    checkOutput("wr_done", {62'd0, a_done, b_done}, 64'd2);
    a_req = 0;
    applyStimulus(1);
    checkOutput("wr_done_off", {62'd0, a_done, b_done}, 64'd0);

    // Single read from A with ideal RAM: done four cycles on.
    $display("[TB] single read");
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    applyStimulus(1);
    checkOutput("rd_load", {62'd0, mem_save, mem_load}, 64'd1);
    applyStimulus(1);
    checkOutput("rd_load_off", {62'd0, mem_save, mem_load}, 64'd0);
    checkOutput("rd_done_e2", 64'(a_done), 64'd0);
    applyStimulus(1);
    checkOutput("rd_done_e3", 64'(a_done), 64'd0);
    applyStimulus(1);
    checkOutput("rd_done", {62'd0, a_done, b_done}, 64'd2);
    checkOutput("rd_data", a_rdata, 64'h0004_0003_0002_0001);
    a_req = 0;
    applyStimulus(1);
    checkOutput("rd_done_off", 64'(a_done), 64'd0);
    checkOutput("rd_data_hold", a_rdata, 64'h0004_0003_0002_0001);

    // Contention after reset: A first, then B while A re-requests.
    $display("[TB] contention");
    rst = 1'b0;
    #2 rst = 1'b1;
    a_req = 1; a_we = 1; a_addr = 16'h0020;
    a_wdata = {16'h14, 16'h13, 16'h12, 16'h11};
    b_req = 1; b_we = 1; b_addr = 16'h0030;
    b_wdata = {16'h24, 16'h23, 16'h22, 16'h21};
    applyStimulus(1);
    checkOutput("cont_first_addr", 64'(mem_address), 64'h0020);
    applyStimulus(1);
    checkOutput("cont_first_done", {62'd0, a_done, b_done}, 64'd2);
    a_addr = 16'h0040;
    a_wdata = {16'h34, 16'h33, 16'h32, 16'h31};
    applyStimulus(2);
    checkOutput("cont_second_addr", 64'(mem_address), 64'h0030);
    checkOutput("cont_second_in0", 64'(mem_in0), 64'h0021);
    applyStimulus(1);
    checkOutput("cont_second_done", {62'd0, a_done, b_done}, 64'd1);
    b_req = 0;

    // Back-to-back A: exactly one IDLE cycle between DONE and next ISSUE.
    $display("[TB] back-to-back");
    applyStimulus(1);
    checkOutput("b2b_idle1", 64'(mem_save), 64'd0);
    applyStimulus(1);
    checkOutput("b2b_issue1", {mem_address, 47'd0, mem_save}, {16'h0040, 47'd0, 1'b1});
    applyStimulus(1);
    checkOutput("b2b_done1", 64'(a_done), 64'd1);
    a_addr = 16'h0050;
    a_wdata = {16'h44, 16'h43, 16'h42, 16'h41};
    applyStimulus(1);
    checkOutput("b2b_idle2", {62'd0, mem_save, a_done}, 64'd0);
    applyStimulus(1);
    checkOutput("b2b_issue2", {mem_address, 47'd0, mem_save}, {16'h0050, 47'd0, 1'b1});
    applyStimulus(1);
    checkOutput("b2b_done2", 64'(a_done), 64'd1);
    a_req = 0;
    applyStimulus(1);

    // B reads back the block it wrote.
    $display("[TB] B read");
    b_req = 1; b_we = 0; b_addr = 16'h0030;
    applyStimulus(1);
    checkOutput("brd_load", {mem_address, 47'd0, mem_load}, {16'h0030, 47'd0, 1'b1});
    applyStimulus(3);
    checkOutput("brd_done", {62'd0, a_done, b_done}, 64'd1);
    checkOutput("brd_data", b_rdata, 64'h0024_0023_0022_0021);
    b_req = 0;
    applyStimulus(1);
    checkOutput("brd_done_off", 64'(b_done), 64'd0);

`ifdef TC_RAM_ARB_TIMEOUT_EN
    // RAM never answers: watchdog completes the read with zero data.
    $display("[TB] timeout");
    ramEnable = 1'b0;
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    applyStimulus(1);
    cyc = 0;
    doneSeen = 0;
    while (!doneSeen && cyc < 400) begin
      applyStimulus(1);
      cyc++;
      if (a_done) doneSeen = 1;
    end
    a_req = 0;
    checkOutput("to_latency", 64'(cyc), 64'd257);
    checkOutput("to_rdata", a_rdata, 64'd0);
    checkOutput("to_err", 64'(timeout_err), 64'd1);
    applyStimulus(3);
    checkOutput("to_err_sticky", 64'(timeout_err), 64'd1);
    ramEnable = 1'b1;
`endif

    // Reset during WAIT: outputs clear at once, late ready is ignored.
    $display("[TB] reset mid-read");
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    applyStimulus(1);
    checkOutput("mrst_load", 64'(mem_load), 64'd1);
    applyStimulus(1);
    a_req = 0;
    rst = 1'b0;
    #1;
    checkOutput("mrst_outputs", {mem_address, 13'd0, mem_load, mem_save, a_done, b_done, 16'd0, mem_in0},
                64'd0);
    checkOutput("mrst_a_rdata", a_rdata, 64'd0);
    #1 rst = 1'b1;
    applyStimulus(1);
    checkOutput("mrst_done_e2", {62'd0, a_done, b_done}, 64'd0);
    applyStimulus(1);
    checkOutput("mrst_done_e3", {61'd0, mem_load, a_done, b_done}, 64'd0);
    applyStimulus(1);
    checkOutput("mrst_done_e4", {62'd0, a_done, b_done}, 64'd0);
    checkOutput("mrst_rdata_e4", a_rdata, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
